// File: rtl/keyboard_decoder.sv
// PS/2 keyboard receiver and Set-2 decoder for a small key set (WASD, 1-4, Esc).
// Optional macro PS2_PARITY_CHECK_EN enables rejection of frames with bad odd parity.
module keyboard_decoder #(
    parameter int TIMEOUT_CYCLES = 65000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic {IDLE, RECV} state_t;

    state_t          state, state_nxt;
    logic [1:0]      clk_sync, data_sync;
    logic            clk_prev;
    logic            fall, bit_in;
    logic [3:0]      bit_cnt, bit_cnt_nxt;
    logic [7:0]      shift, shift_nxt;
    logic [TW-1:0]   tcnt, tcnt_nxt;
    logic            brk, brk_nxt, ext, ext_nxt;
    logic [3:0]      key_code_nxt;
    logic            key_valid_nxt, frame_err_nxt;
    logic [3:0]      mapped;
    logic            par_bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall   = clk_prev & ~clk_sync[1];
    assign bit_in = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
    logic parity;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   parity <= 1'b0;
        else if (fall && state == RECV && bit_cnt == 4'd8) parity <= bit_in;
    end
    // Odd parity: data plus parity must carry an odd number of ones.
    assign par_bad = ~(^{shift, parity});
`else
    assign par_bad = 1'b0;
`endif

    always_comb begin
        case (shift)
            8'h1C:   mapped = 4'd1;
            8'h1B:   mapped = 4'd2;
            8'h1D:   mapped = 4'd3;
            8'h23:   mapped = 4'd4;
            8'h16:   mapped = 4'd5;
            8'h1E:   mapped = 4'd6;
            8'h26:   mapped = 4'd7;
            8'h25:   mapped = 4'd8;
            8'h76:   mapped = 4'd9;
            default: mapped = 4'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            tcnt      <= '0;
            brk       <= 1'b0;
            ext       <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            tcnt      <= tcnt_nxt;
            brk       <= brk_nxt;
            ext       <= ext_nxt;
            key_code  <= key_code_nxt;
            key_valid <= key_valid_nxt;
            frame_err <= frame_err_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        tcnt_nxt      = tcnt;
        brk_nxt       = brk;
        ext_nxt       = ext;
        key_code_nxt  = key_code;
        key_valid_nxt = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !bit_in) begin
                    state_nxt   = RECV;
                    bit_cnt_nxt = '0;
                    tcnt_nxt    = '0;
                end
            end
            RECV: begin
                if (fall) begin
                    tcnt_nxt    = '0;
                    bit_cnt_nxt = bit_cnt + 4'd1;
                    if (bit_cnt < 4'd8) shift_nxt = {bit_in, shift[7:1]};
                    // bit_cnt 9 is the stop bit: the whole frame is decided here
                    if (bit_cnt == 4'd9) begin
                        state_nxt = IDLE;
                        if (!bit_in || par_bad) begin
                            frame_err_nxt = 1'b1;
                        end else if (shift == 8'hF0) begin
                            brk_nxt = 1'b1;
                        end else if (shift == 8'hE0) begin
                            ext_nxt = 1'b1;
                        end else if (ext) begin
                            ext_nxt = 1'b0;
                            brk_nxt = 1'b0;
                        end else begin
                            brk_nxt = 1'b0;
                            if (mapped != 4'd0) begin
                                if (brk) begin
                                    if (mapped == key_code) begin
                                        key_code_nxt  = 4'd0;
                                        key_valid_nxt = 1'b1;
                                    end
                                end else if (mapped != key_code) begin
                                    key_code_nxt  = mapped;
                                    key_valid_nxt = 1'b1;
                                end
                            end
                        end
                    end
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keyboard_decoder.sv
// Randomized PS/2 frame bench for keyboard_decoder with a scan-code level reference model.
module tb_keyboard_decoder;
    localparam int TO = 200;
    localparam int H  = 8;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [3:0] key_code;
    logic       key_valid, frame_err;

    keyboard_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key_code(key_code), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int chk_cnt = 0, pass_cnt = 0;
    int vcnt = 0, ecnt = 0, both_cnt = 0;

    always @(negedge clk) begin
        if (key_valid) vcnt++;
        if (frame_err) ecnt++;
        if (key_valid && frame_err) both_cnt++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        else pass_cnt++;
    endtask

    // Reference model: scan-code semantics only.
    byte unsigned codes[9] = '{8'h1C, 8'h1B, 8'h1D, 8'h23, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h76};
    int  mkey = 0;
    bit  mbrk = 0, mext = 0;

    function automatic int mapkey(input byte unsigned b);
        for (int i = 0; i < 9; i++) if (codes[i] == b) return i + 1;
        return 0;
    endfunction

    task automatic model(input byte unsigned b, input bit par_ok, input bit stop_ok,
                         output bit ev, output bit ee);
        int k;
        ev = 0; ee = 0;
        if (!stop_ok || (PAR_EN && !par_ok)) ee = 1;
        else if (b == 8'hF0) mbrk = 1;
        else if (b == 8'hE0) mext = 1;
        else if (mext) begin mext = 0; mbrk = 0; end
        else begin
            k = mapkey(b);
            if (k != 0) begin
                if (mbrk) begin
                    if (k == mkey) begin mkey = 0; ev = 1; end
                end else if (k != mkey) begin
                    mkey = k; ev = 1;
                end
            end
            mbrk = 0;
        end
    endtask

    task automatic pulse_bit(input logic b);
        @(negedge clk); ps2_data = b;
        repeat (H - 1) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (H) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input byte unsigned b, input bit bad_par, input bit bad_stop);
        logic [10:0] bits;
        logic par;
        int v0, e0;
        bit ev, ee;
        par  = ~(^b) ^ bad_par;
        bits = {~bad_stop, par, b, 1'b0};
        v0 = vcnt; e0 = ecnt;
        model(b, !bad_par, !bad_stop, ev, ee);
        for (int i = 0; i < 10; i++) pulse_bit(bits[i]);
        @(negedge clk); ps2_data = bits[10];
        repeat (H - 1) @(negedge clk);
        ps2_clk = 1'b0;
        // two sync flops + edge detect, then the registered outputs
        repeat (3) @(posedge clk);
        #1;
        chk("key_valid_lat", key_valid, ev);
        chk("frame_err_lat", frame_err, ee);
        chk("key_code", key_code, mkey);
        repeat (H - 1) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
        chk("valid_pulses", vcnt - v0, ev);
        chk("err_pulses", ecnt - e0, ee);
    endtask

    initial begin
        int v0, e0, r;
        byte unsigned b;
        #1;
        chk("rst_key_code", key_code, 0);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send_frame(8'h1C, 0, 0);
        chk("a_make", key_code, 4'b0001);
        v0 = vcnt;
        send_frame(8'h1C, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("repeat_no_pulse", vcnt - v0, 0);
        chk("repeat_key", key_code, 4'b0001);

        send_frame(8'h1D, 0, 0);
        chk("w_make", key_code, 4'b0011);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("other_break", key_code, 4'b0011);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1D, 0, 0);
        chk("w_break", key_code, 4'b0000);

        send_frame(8'hE0, 0, 0);
        send_frame(8'h1C, 0, 0);
        chk("ext_ignored", key_code, 4'b0000);
        send_frame(8'h76, 0, 0);
        chk("esc_make", key_code, 4'b1001);

        // truncated frame: start + 4 data bits, then silence
        v0 = vcnt; e0 = ecnt;
        pulse_bit(1'b0);
        for (int i = 0; i < 4; i++) pulse_bit(1'b1);
        repeat (TO - 3 * H) @(negedge clk);
        chk("no_early_timeout", ecnt - e0, 0);
        repeat (4 * H) @(negedge clk);
        chk("timeout_err", ecnt - e0, 1);
        chk("timeout_no_valid", vcnt - v0, 0);
        chk("timeout_key", key_code, 4'b1001);
        send_frame(8'h23, 0, 0);
        chk("d_after_timeout", key_code, 4'b0100);

        send_frame(8'h1B, 0, 1);
        chk("bad_stop_key", key_code, 4'b0100);
        send_frame(8'h1B, 1, 0);
        chk("bad_parity_key", key_code, PAR_EN ? 4'b0100 : 4'b0010);

        // reset in the middle of a frame
        pulse_bit(1'b0);
        for (int i = 0; i < 3; i++) pulse_bit(1'b1);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("midframe_rst_key", key_code, 0);
        mkey = 0; mbrk = 0; mext = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h1E, 0, 0);
        chk("after_rst_make", key_code, 4'b0110);

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 11);
            if (r < 7)       b = codes[$urandom_range(0, 8)];
            else if (r < 9)  b = 8'hF0;
            else if (r == 9) b = 8'hE0;
            else             b = 8'($urandom);
            send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end

        chk("valid_err_exclusive", both_cnt, 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
